// File: rtl/fft_out_reorder.sv
`default_nettype none
// =============================================================================
// fft_out_reorder - captures bit-reversed 4-lane FFT frames into a ping-pong
// buffer and replays them in natural bin order, four bins per beat.  Rev 1.0
// =============================================================================
module fft_out_reorder #(
  parameter int NBITS = 10,
  parameter int N     = 128,
  parameter int DW    = ((NBITS + 1) * 2 + 1) * 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in0_up,
  input  logic [DW-1:0] in0_down,
  input  logic [DW-1:0] in1_up,
  input  logic [DW-1:0] in1_down,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3,
  output logic          overflow
);

  localparam int LOGN = $clog2(N);
  localparam int CW   = LOGN - 2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N / 4 - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            drop_q, drop_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      full_q, full_d;
  logic            out_valid_q, out_valid_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q [4];
  logic [DW-1:0]   out_data_d [4];

  logic [DW-1:0]   mem_q [2][N];
  logic [DW-1:0]   lane_data [4];
  logic [LOGN-1:0] wr_addr [4];
  logic [1:0]      full_clr;
  logic [1:0]      full_avail;
  logic            wr_accept;
  logic            slot_free;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  assign lane_data[0] = in0_up;
  assign lane_data[1] = in0_down;
  assign lane_data[2] = in1_up;
  assign lane_data[3] = in1_down;

  // The bank is released as soon as its last beat moves into the output
  // register, so a writer starting a frame in that same cycle can reuse it.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    full_clr    = 2'b00;
    slot_free   = !out_valid_q || out_ready;

    if (state_q == ST_IDLE && full_q[rd_bank_q]) state_d = ST_READ;

    if (slot_free) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (state_q == ST_READ && slot_free) begin
      out_valid_d = 1'b1;
      out_first_d = (rd_cnt_q == '0);
      out_last_d  = (rd_cnt_q == LAST_BEAT);
      for (int k = 0; k < 4; k++) out_data_d[k] = mem_q[rd_bank_q][{rd_cnt_q, 2'(k)}];
      if (rd_cnt_q == LAST_BEAT) begin
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = !rd_bank_q;
        rd_cnt_d            = '0;
        state_d             = full_q[!rd_bank_q] ? ST_READ : ST_IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    full_avail = full_q & ~full_clr;
    full_d     = full_avail;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    wr_accept  = 1'b0;

    if (in_valid) begin
      if (wr_cnt_q == '0) begin
        wr_accept = !full_avail[wr_bank_q];
        drop_d    = !wr_accept;
        if (!wr_accept) overflow_d = 1'b1;
      end else begin
        wr_accept = !drop_q;
      end
      wr_cnt_d = (wr_cnt_q == LAST_BEAT) ? '0 : wr_cnt_q + CW'(1);
      if (wr_accept && wr_cnt_q == LAST_BEAT) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) wr_addr[l] = bitrev({wr_cnt_q, 2'(l)});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
      full_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < 4; k++) out_data_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      drop_q      <= drop_d;
      overflow_q  <= overflow_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int l = 0; l < 4; l++) mem_q[wr_bank_q][wr_addr[l]] <= lane_data[l];
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out0      = out_data_q[0];
  assign out1      = out_data_q[1];
  assign out2      = out_data_q[2];
  assign out3      = out_data_q[3];
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
